// File: rtl/h80bus_pkg.sv
// Shared h80 bus arbiter definitions: command encodings, FSM state type and
// the read-class helper used by the arbiter top.
package h80bus_pkg;

    localparam logic [2:0] BUS_CMD_WRITE   = 3'b000;
    localparam logic [2:0] BUS_CMD_READ    = 3'b001;
    localparam logic [2:0] BUS_CMD_WRITE_W = 3'b010;
    localparam logic [2:0] BUS_CMD_READ_W  = 3'b011;
    localparam logic [2:0] BUS_CMD_WRITE_B = 3'b100;
    localparam logic [2:0] BUS_CMD_READ_B  = 3'b101;

    localparam int CMD_W_MAX = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Read-class commands have bit 0 set; masking keeps every input bit referenced.
    function automatic logic is_read(input logic [CMD_W_MAX-1:0] cmd);
        return (cmd & CMD_W_MAX'(1)) != '0;
    endfunction

endpackage

// File: rtl/h80bus_rr_pick.sv
// Combinational round-robin picker: first requester at or after start, with
// the excl master only eligible when it is the sole requester.
module h80bus_rr_pick #(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] start,
    input  logic [$clog2(NUM_MASTERS)-1:0] excl,
    output logic                           found,
    output logic [$clog2(NUM_MASTERS)-1:0] pick
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] excl_mask;
    logic [NUM_MASTERS-1:0] others;
    logic [NUM_MASTERS-1:0] cand;
    int                     j;

    always_comb begin
        excl_mask       = '0;
        excl_mask[excl] = 1'b1;
        others          = req & ~excl_mask;
        cand            = (|others) ? others : req;
        found           = |cand;
        pick            = '0;
        j               = 0;
        // Walk backwards so the candidate closest to start is written last.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            if (cand[j]) pick = IDX_W'(j);
        end
    end

endmodule

// File: rtl/h80bus_arbiter.sv
// Round-robin arbiter sharing one h80 bus slave between NUM_MASTERS masters.
// Optional H80BUS_ARB_LOCK_EN adds m_lock to hold the grant across beats.
module h80bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_MASTERS-1:0]                 m_ce_n,
    input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_MASTERS*BUS_CMD_WIDTH-1:0]   m_cmd,
    input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0]  m_wdata,
`ifdef H80BUS_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]                 m_lock,
`endif
    output logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0]  m_rdata,
    output logic [NUM_MASTERS-1:0]                 m_wait_n,
    output logic                                   s_ce_n,
    output logic [BUS_ADDR_WIDTH-1:0]              s_addr,
    output logic [BUS_CMD_WIDTH-1:0]               s_cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0]              s_data_,
    input  logic                                   s_wait_n,
    output logic                                   grant_valid,
    output logic [$clog2(NUM_MASTERS)-1:0]         grant_idx
);
    import h80bus_pkg::*;

    // state | meaning
    // IDLE  | no grant held; arbitrate among requesters on the next edge
    // OWNED | grant_idx is wired through to the slave until its beat ends

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    grant_nxt, last_idx, last_nxt;
    logic [IDX_W-1:0]    base_idx, start_idx, pick;
    logic                found, lock_hold, rd_g, drive_en;

    logic [BUS_ADDR_WIDTH-1:0] addr_a  [NUM_MASTERS];
    logic [BUS_CMD_WIDTH-1:0]  cmd_a   [NUM_MASTERS];
    logic [BUS_DATA_WIDTH-1:0] wdata_a [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign addr_a[i]  = m_addr[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
        assign cmd_a[i]   = m_cmd[i*BUS_CMD_WIDTH +: BUS_CMD_WIDTH];
        assign wdata_a[i] = m_wdata[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end

`ifdef H80BUS_ARB_LOCK_EN
    assign lock_hold = m_lock[grant_idx];
`else
    assign lock_hold = 1'b0;
`endif

    // IDLE searches after last_idx, a completing beat searches after the owner;
    // in both cases that master is the one only eligible when alone.
    assign base_idx  = (state == OWNED) ? grant_idx : last_idx;
    assign start_idx = (base_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : base_idx + 1'b1;

    h80bus_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .req   (~m_ce_n),
        .start (start_idx),
        .excl  (base_idx),
        .found (found),
        .pick  (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_nxt;
            last_idx  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_idx;
        last_nxt  = last_idx;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWNED;
                    grant_nxt = pick;
                end
            end
            OWNED: begin
                if (m_ce_n[grant_idx]) begin
                    state_nxt = IDLE;
                end else if (s_wait_n) begin
                    last_nxt = grant_idx;
                    if (lock_hold)  grant_nxt = grant_idx;
                    else if (found) grant_nxt = pick;
                    else            state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_valid = (state == OWNED);
    assign rd_g        = is_read(CMD_W_MAX'(cmd_a[grant_idx]));

    always_comb begin
        s_ce_n = 1'b1;
        s_addr = '0;
        s_cmd  = '0;
        if (grant_valid) begin
            s_ce_n = m_ce_n[grant_idx];
            s_addr = addr_a[grant_idx];
            s_cmd  = cmd_a[grant_idx];
        end
    end

    assign drive_en = grant_valid && !s_ce_n && !rd_g;
    assign s_data_  = drive_en ? wdata_a[grant_idx] : {BUS_DATA_WIDTH{1'bz}};

    // Losing requesters stall; idle masters see wait_n high.
    always_comb begin
        m_wait_n = m_ce_n;
        m_rdata  = '0;
        if (grant_valid) begin
            m_wait_n[grant_idx] = s_wait_n;
            if (rd_g) m_rdata[grant_idx*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = s_data_;
        end
    end

endmodule

// File: tb/tb_h80bus_arbiter.sv
// Scoreboard bench for h80bus_arbiter with a memory slave model; the lock
// scenario is built only when H80BUS_ARB_LOCK_EN is defined.
module tb_h80bus_arbiter;
    import h80bus_pkg::*;

    localparam int NM = 2;
    localparam int AW = 16;
    localparam int CW = 3;
    localparam int DW = 16;

    typedef struct {
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          lock;
    } op_t;

    typedef struct {
        int            master;
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_ce_n;
    logic [NM*AW-1:0] m_addr;
    logic [NM*CW-1:0] m_cmd;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*DW-1:0] m_rdata;
    logic [NM-1:0]    m_wait_n;
    logic             s_ce_n;
    logic [AW-1:0]    s_addr;
    logic [CW-1:0]    s_cmd;
    wire  [DW-1:0]    s_data_;
    logic             s_wait_n;
    logic             grant_valid;
    logic [$clog2(NM)-1:0] grant_idx;

    logic          ce_a    [NM] = '{default: 1'b1};
    logic [AW-1:0] addr_a  [NM] = '{default: '0};
    logic [CW-1:0] cmd_a   [NM] = '{default: '0};
    logic [DW-1:0] wdata_a [NM] = '{default: '0};
`ifdef H80BUS_ARB_LOCK_EN
    logic [NM-1:0] m_lock;
    logic          lock_a  [NM] = '{default: 1'b0};
`endif

    always_comb begin
        m_ce_n  = '1;
        m_addr  = '0;
        m_cmd   = '0;
        m_wdata = '0;
        for (int i = 0; i < NM; i++) begin
            m_ce_n[i]            = ce_a[i];
            m_addr[i*AW +: AW]   = addr_a[i];
            m_cmd[i*CW +: CW]    = cmd_a[i];
            m_wdata[i*DW +: DW]  = wdata_a[i];
        end
    end
`ifdef H80BUS_ARB_LOCK_EN
    always_comb begin
        m_lock = '0;
        for (int i = 0; i < NM; i++) m_lock[i] = lock_a[i];
    end
`endif

    h80bus_arbiter #(
        .NUM_MASTERS(NM), .BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW), .BUS_DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset),
        .m_ce_n(m_ce_n), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
`ifdef H80BUS_ARB_LOCK_EN
        .m_lock(m_lock),
`endif
        .m_rdata(m_rdata), .m_wait_n(m_wait_n),
        .s_ce_n(s_ce_n), .s_addr(s_addr), .s_cmd(s_cmd), .s_data_(s_data_),
        .s_wait_n(s_wait_n), .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    // Memory slave: wait_cfg wait states per beat, write lands on the completing edge.
    logic [DW-1:0] mem [0:255] = '{default: '0};
    int ws;
    int wait_cfg;
    assign s_wait_n = (ws >= wait_cfg);
    assign s_data_  = (!s_ce_n && s_cmd[0]) ? mem[s_addr[7:0]] : {DW{1'bz}};

    always @(posedge clk or posedge reset) begin
        if (reset) ws <= 0;
        else if (!s_ce_n) begin
            if (s_wait_n) begin
                ws <= 0;
                if (!s_cmd[0]) mem[s_addr[7:0]] <= s_data_;
            end else ws <= ws + 1;
        end else ws <= 0;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    op_t  op_q [NM][$];
    exp_t exp_q [$];
    int   done_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic add_op(input int m, input logic [CW-1:0] c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic lk);
        op_t o;
        o.cmd = c; o.addr = a; o.wdata = d; o.lock = lk;
        op_q[m].push_back(o);
    endtask

    task automatic expect_beat(input int m, input logic [CW-1:0] c, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        exp_t e;
        e.master = m; e.cmd = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // A beat is presented when a requesting master sees wait_n high; it completes next edge.
    exp_t          mon_e;
    logic [DW-1:0] mon_d;
    always @(negedge clk) begin
        for (int i = 0; i < NM; i++) begin
            if (!m_ce_n[i] && m_wait_n[i]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat master=%0d addr=%h", i, s_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_d = mon_e.cmd[0] ? m_rdata[i*DW +: DW] : s_data_;
                    chk("beat_master", 32'(i), 32'(mon_e.master));
                    chk("beat_grant", 32'(grant_idx), 32'(mon_e.master));
                    chk("beat_addr", 32'(s_addr), 32'(mon_e.addr));
                    chk("beat_cmd", 32'(s_cmd), 32'(mon_e.cmd));
                    chk("beat_data", 32'(mon_d), 32'(mon_e.data));
                    done_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic drive(input int m);
        op_t o;
        int  guard;
        while (op_q[m].size() > 0) begin
            o = op_q[m].pop_front();
            ce_a[m] = 1'b0; cmd_a[m] = o.cmd; addr_a[m] = o.addr; wdata_a[m] = o.wdata;
`ifdef H80BUS_ARB_LOCK_EN
            lock_a[m] = o.lock;
`endif
            guard = 0;
            @(negedge clk);
            while (!m_wait_n[m] && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout master=%0d addr=%h", m, o.addr);
            end
            @(posedge clk); #1;
        end
        ce_a[m] = 1'b1;
`ifdef H80BUS_ARB_LOCK_EN
        lock_a[m] = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_both();
        fork
            drive(0);
            drive(1);
        join
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int guard;
        reset = 1'b1;
        wait_cfg = 0;
        idle(2);
        reset = 1'b0;
        #1;
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        chk("rst_s_ce_n", 32'(s_ce_n), 32'd1);
        chk("rst_m_rdata", 32'(m_rdata), 32'd0);
        chk("rst_m_wait_n", 32'(m_wait_n), 32'h3);
        idle(1);

        // single master write then read back
        add_op(0, BUS_CMD_WRITE, 16'h0010, 16'hBEEF, 1'b0);
        add_op(0, BUS_CMD_READ,  16'h0010, 16'h0000, 1'b0);
        expect_beat(0, BUS_CMD_WRITE, 16'h0010, 16'hBEEF);
        expect_beat(0, BUS_CMD_READ,  16'h0010, 16'hBEEF);
        fork
            run_both();
            begin
                @(negedge clk);
                chk("first_wait_stall", 32'(m_wait_n[0]), 32'd0);
                chk("first_s_ce_n", 32'(s_ce_n), 32'd1);
            end
        join

        // both masters from reset: strict alternation, no bubbles
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            add_op(0, BUS_CMD_WRITE, 16'h0020 + 16'(k), 16'hA001 + 16'(k), 1'b0);
            add_op(1, BUS_CMD_WRITE, 16'h0030 + 16'(k), 16'hB001 + 16'(k), 1'b0);
            expect_beat(0, BUS_CMD_WRITE, 16'h0020 + 16'(k), 16'hA001 + 16'(k));
            expect_beat(1, BUS_CMD_WRITE, 16'h0030 + 16'(k), 16'hB001 + 16'(k));
        end
        done_cyc.delete();
        run_both();
        chk("rr_beat_count", 32'(done_cyc.size()), 32'd6);
        if (done_cyc.size() == 6) chk("rr_no_bubble", 32'(done_cyc[5] - done_cyc[0]), 32'd5);

        // slave wait states during master 1 read while master 0 waits
        idle(3);
        wait_cfg = 3;
        add_op(1, BUS_CMD_READ, 16'h0030, 16'h0000, 1'b0);
        add_op(0, BUS_CMD_READ, 16'h0021, 16'h0000, 1'b0);
        expect_beat(1, BUS_CMD_READ, 16'h0030, 16'hB001);
        expect_beat(0, BUS_CMD_READ, 16'h0021, 16'hA002);
        fork
            drive(1);
            begin
                @(posedge clk); #1;
                drive(0);
            end
            begin
                guard = 0;
                while (!(grant_valid && grant_idx == 1'b1) && guard < 20) begin
                    @(negedge clk);
                    guard++;
                end
                n = 0;
                while (grant_valid && grant_idx == 1'b1 && n < 20) begin
                    chk("m0_stalled", 32'(m_wait_n[0]), 32'd0);
                    n++;
                    @(negedge clk);
                end
                chk("hold_cycles", 32'(n), 32'd4);
            end
        join
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // master 0 abandons mid-beat; pending master 1 follows via IDLE
        idle(3);
        add_op(1, BUS_CMD_READ, 16'h0031, 16'h0000, 1'b0);
        expect_beat(1, BUS_CMD_READ, 16'h0031, 16'hB002);
        fork
            begin
                ce_a[0] = 1'b0; cmd_a[0] = BUS_CMD_READ; addr_a[0] = 16'h0022;
                idle(2);
                ce_a[0] = 1'b1;
            end
            begin
                @(posedge clk); #1;
                drive(1);
            end
            begin
                @(negedge clk);
                chk("ab_idle_first", 32'(grant_valid), 32'd0);
                @(negedge clk);
                chk("ab_grant0", 32'({grant_valid, grant_idx}), 32'h2);
                chk("ab_m1_stall", 32'(m_wait_n[1]), 32'd0);
                @(negedge clk);
                chk("ab_released_sce", 32'(s_ce_n), 32'd1);
                @(negedge clk);
                chk("ab_back_idle", 32'(grant_valid), 32'd0);
                @(negedge clk);
                chk("ab_grant1", 32'({grant_valid, grant_idx}), 32'h3);
            end
        join
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a stalled write
        idle(3);
        ce_a[1] = 1'b0; cmd_a[1] = BUS_CMD_WRITE; addr_a[1] = 16'h0040; wdata_a[1] = 16'h1234;
        idle(1);
        @(posedge clk); #3;
        chk("pre_rst_s_ce_n", 32'(s_ce_n), 32'd0);
        chk("pre_rst_data", 32'(s_data_), 32'h1234);
        reset = 1'b1;
        #1;
        chk("rst_mid_s_ce_n", 32'(s_ce_n), 32'd1);
        chk("rst_mid_data_hiz", 32'(s_data_ === 16'h1234), 32'd0);
        chk("rst_mid_grant", 32'(grant_valid), 32'd0);
        ce_a[1] = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        wait_cfg = 0;
        add_op(0, BUS_CMD_READ, 16'h0040, 16'h0000, 1'b0);
        add_op(1, BUS_CMD_READ, 16'h0010, 16'h0000, 1'b0);
        expect_beat(0, BUS_CMD_READ, 16'h0040, 16'h0000);
        expect_beat(1, BUS_CMD_READ, 16'h0010, 16'hBEEF);
        run_both();

`ifdef H80BUS_ARB_LOCK_EN
        // locked read-modify-write keeps master 1 out for three beats
        idle(3);
        add_op(0, BUS_CMD_READ,  16'h0020, 16'h0000, 1'b1);
        add_op(0, BUS_CMD_WRITE, 16'h0020, 16'h5A5A, 1'b1);
        add_op(0, BUS_CMD_READ,  16'h0020, 16'h0000, 1'b0);
        add_op(1, BUS_CMD_READ,  16'h0030, 16'h0000, 1'b0);
        expect_beat(0, BUS_CMD_READ,  16'h0020, 16'hA001);
        expect_beat(0, BUS_CMD_WRITE, 16'h0020, 16'h5A5A);
        expect_beat(0, BUS_CMD_READ,  16'h0020, 16'h5A5A);
        expect_beat(1, BUS_CMD_READ,  16'h0030, 16'hB001);
        run_both();
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
